line_refresh_scheduler: RTL and testbench
=========================================

# line_refresh_scheduler

Consumes the stale-line indication from the L1 staleness tracker and converts it into a stream of per-line refresh requests to the cache controller. It also generates the tracker's periodic `tick_en`. A round-robin sweep pointer over (set, way) issues a bounded burst of refreshes per stale event. Each accepted refresh is echoed back as a completion pulse, which the integrator ORs into the tracker's access-clear path. Saturating counters provide timing/refresh instrumentation.

## Interface
Parameters:
- `NUM_SETS`, 64, number of cache sets
- `NUM_WAYS`, 4, associativity
- `INDEX_BITS`, `$clog2(NUM_SETS)`, set index width
- `WAY_BITS`, `(NUM_WAYS>1)?$clog2(NUM_WAYS):1`, way width

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `enable` in 1: global enable for ticks and bursts
- `tick_period` in 16: cycles between `tick_en` pulses; 0 disables ticks
- `tick_en` out 1: one-cycle pulse to the stale tracker
- `stale_event` in 1: one-cycle pulse from the stale tracker
- `refresh_budget` in 8: lines per burst; 0 means full sweep (`NUM_SETS*NUM_WAYS`)
- `refresh_valid` out 1: refresh request valid
- `refresh_ready` in 1: controller accepts the request
- `refresh_index` out INDEX_BITS: set of the request
- `refresh_way` out WAY_BITS: way of the request
- `refresh_done` out 1: pulse, one cycle after each accepted request
- `refresh_done_index` out INDEX_BITS / `refresh_done_way` out WAY_BITS: line just refreshed
- `busy` out 1: FSM not IDLE
- `refresh_count` out 16: accepted refreshes, saturating at 0xFFFF
- `dropped_events` out 8: stale events lost, saturating at 0xFF

## Operation
- Reset: all outputs 0; sweep pointer (0,0); pending 0; FSM IDLE; tick counter 0.
- Tick generation:
  - While `enable` and `tick_period!=0`, the counter increments each cycle.
  - When counter `>= tick_period-1`: pulse `tick_en` and clear the counter. The `>=` compare covers a shrinking period.
  - When `enable=0` or period is 0: counter held at 0, no pulse.
- Pending flag: `stale_event` sets pending. If pending is already 1, or is being consumed on the same edge, `dropped_events` increments instead.
- FSM states are IDLE and ISSUE.
  - IDLE → ISSUE when `enable && pending`. On this edge: load `remaining` with the budget (0 maps to `NUM_SETS*NUM_WAYS`), clear pending, assert `refresh_valid` with the current pointer.
  - ISSUE, on `refresh_valid && refresh_ready`:
    - Pulse `refresh_done` with the accepted index/way.
    - Increment `refresh_count`.
    - Advance the pointer: way+1; on `NUM_WAYS-1` wrap way to 0 and set+1; set wraps from `NUM_SETS-1` to 0.
    - Decrement `remaining`.
    - If `remaining` was 1, or `enable=0`: go to IDLE and drop `refresh_valid`. Otherwise keep `refresh_valid` high with the new pointer.
- Handshake rules:
  - Once `refresh_valid` is asserted, it and index/way stay stable until accepted.
  - `enable` falling does not retract an outstanding request. It ends the burst after the next acceptance; the unused budget is discarded and pending is kept.
- The pointer persists across bursts, so successive bursts continue round-robin.
- Mid-burst `rst_n=0`: the next edge returns everything to reset values and no `refresh_done` is emitted.

## Timing
- `stale_event` high at edge E → pending set at E → `refresh_valid` high after edge E+1 (2-cycle latency from IDLE).
- Throughput: one refresh per cycle when `refresh_ready` is held high.
- `refresh_done` is registered: high exactly the cycle after the accepting edge.
- `tick_en` first pulse appears `tick_period` cycles after `enable` rises from reset.
- `busy` is high exactly while the FSM is in ISSUE.

## Structure
- Shared package `l1_cache_pkg`:
  - `NUM_SETS` / `NUM_WAYS` defaults
  - FSM state typedef `refresh_state_t` (IDLE, ISSUE)
  - saturation limits for the 16-bit and 8-bit counters
- Sub-module `tick_prescaler`: 16-bit counter with `tick_period`/`enable` inputs and `tick_en` output. The rest of the logic lives in the top.

## Test plan
- `tick_period=4`, `enable=1` from cycle 0: `tick_en` pulses at cycles 4, 8, 12; switch to 0 → no further pulses; switch 100→2 with counter at 50 → pulse next cycle.
- `refresh_budget=3`, ready tied 1, single `stale_event`: requests (0,0),(0,1),(0,2) back-to-back, `refresh_done` each one cycle later, `refresh_count=3`. A second event issues (0,3),(1,0),(1,1).
- Ready held 0 for 5 cycles during a burst: valid and index/way unchanged all 5 cycles; exactly one `refresh_done` after ready rises.
- `NUM_SETS=2`, `NUM_WAYS=2`, budget=0: four requests (0,0),(0,1),(1,0),(1,1); pointer wraps to (0,0).
- Three `stale_event` pulses while ISSUE with budget=8: pending set once, `dropped_events=2`. After the burst, a new burst starts 1 cycle later from the wrapped pointer.
- `enable` dropped while a request is stalled, then ready asserted: that request completes, FSM returns to IDLE, remaining budget discarded. Separately, `rst_n` low mid-burst: all outputs 0 and pointer (0,0) next cycle.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared L1 cache parameters, refresh FSM state type and counter saturation limits.
package l1_cache_pkg;

    localparam int unsigned L1_NUM_SETS = 64;
    localparam int unsigned L1_NUM_WAYS = 4;

    localparam logic [15:0] REFRESH_CNT_MAX = 16'hFFFF;
    localparam logic [7:0]  DROP_CNT_MAX    = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } refresh_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Periodic one-cycle tick generator for the staleness tracker.
module tick_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] tick_period,
    output logic        tick_en
);

    logic [15:0] r_cnt;
    logic        r_tick;
    logic        w_run;
    logic [15:0] w_last;

    assign w_run  = enable && (tick_period != '0);
    assign w_last = tick_period - 16'd1;

    // ">=" rather than "==" so a period shrunk below the current count fires immediately
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!w_run) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt >= w_last) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_tick <= 1'b0;
        end
    end

    assign tick_en = r_tick;

endmodule

// File: rtl/line_refresh_scheduler.sv
// Turns stale-line events into bounded round-robin bursts of per-line refresh
// requests, echoes accepted requests as done pulses, and drives the tracker tick.
module line_refresh_scheduler
    import l1_cache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = L1_NUM_SETS,
    parameter int unsigned NUM_WAYS   = L1_NUM_WAYS,
    parameter int unsigned INDEX_BITS = $clog2(NUM_SETS),
    parameter int unsigned WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [15:0]           tick_period,
    output logic                  tick_en,
    input  logic                  stale_event,
    input  logic [7:0]            refresh_budget,
    output logic                  refresh_valid,
    input  logic                  refresh_ready,
    output logic [INDEX_BITS-1:0] refresh_index,
    output logic [WAY_BITS-1:0]   refresh_way,
    output logic                  refresh_done,
    output logic [INDEX_BITS-1:0] refresh_done_index,
    output logic [WAY_BITS-1:0]   refresh_done_way,
    output logic                  busy,
    output logic [15:0]           refresh_count,
    output logic [7:0]            dropped_events
);

    localparam int unsigned TOTAL_LINES = NUM_SETS * NUM_WAYS;
    localparam int unsigned REM_BITS    = ($clog2(TOTAL_LINES + 1) > 9) ? $clog2(TOTAL_LINES + 1) : 9;

    refresh_state_t        r_state;
    logic                  r_pending;
    logic [REM_BITS-1:0]   r_remaining;
    logic [INDEX_BITS-1:0] r_set;
    logic [WAY_BITS-1:0]   r_way;
    logic                  r_valid;
    logic                  r_done;
    logic [INDEX_BITS-1:0] r_done_set;
    logic [WAY_BITS-1:0]   r_done_way;
    logic [15:0]           r_count;
    logic [7:0]            r_dropped;

    logic [REM_BITS-1:0]   w_burst_lines;
    logic                  w_accept;
    logic                  w_way_last;
    logic                  w_set_last;

    tick_prescaler u_tick_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .tick_period (tick_period),
        .tick_en     (tick_en)
    );

    assign w_burst_lines = (refresh_budget == '0) ? REM_BITS'(TOTAL_LINES) : REM_BITS'(refresh_budget);
    assign w_accept      = r_valid && refresh_ready;
    assign w_way_last    = (r_way == WAY_BITS'(NUM_WAYS - 1));
    assign w_set_last    = (r_set == INDEX_BITS'(NUM_SETS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_remaining <= '0;
            r_set       <= '0;
            r_way       <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_done_set  <= '0;
            r_done_way  <= '0;
            r_count     <= '0;
            r_dropped   <= '0;
        end else begin
            r_done <= 1'b0;

            // An event arriving while one is already pending (even one being consumed now) is lost
            if (stale_event) begin
                if (r_pending) begin
                    if (r_dropped != DROP_CNT_MAX)
                        r_dropped <= r_dropped + 8'd1;
                end else begin
                    r_pending <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (enable && r_pending) begin
                        r_state     <= ISSUE;
                        r_pending   <= 1'b0;
                        r_remaining <= w_burst_lines;
                        r_valid     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (w_accept) begin
                        r_done     <= 1'b1;
                        r_done_set <= r_set;
                        r_done_way <= r_way;
                        if (r_count != REFRESH_CNT_MAX)
                            r_count <= r_count + 16'd1;
                        if (w_way_last) begin
                            r_way <= '0;
                            r_set <= w_set_last ? '0 : r_set + 1'b1;
                        end else begin
                            r_way <= r_way + 1'b1;
                        end
                        r_remaining <= r_remaining - 1'b1;
                        // Dropping enable only ends the burst at an acceptance; pending survives
                        if ((r_remaining == REM_BITS'(1)) || !enable) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign refresh_valid      = r_valid;
    assign refresh_index      = r_set;
    assign refresh_way        = r_way;
    assign refresh_done       = r_done;
    assign refresh_done_index = r_done_set;
    assign refresh_done_way   = r_done_way;
    assign busy               = (r_state == ISSUE);
    assign refresh_count      = r_count;
    assign dropped_events     = r_dropped;

endmodule

// File: tb/tb_line_refresh_scheduler.sv
// Directed bench for line_refresh_scheduler: default 64x4 instance plus a 2x2 instance for wrap.
module tb_line_refresh_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, stale, ready;
    logic [15:0] period;
    logic [7:0]  budget;
    logic        tick, valid, done, busy;
    logic [5:0]  idx, didx;
    logic [1:0]  way, dway;
    logic [15:0] cnt;
    logic [7:0]  drop;

    logic        s_enable, s_stale, s_ready;
    logic [7:0]  s_budget;
    logic [15:0] s_period;
    logic        s_tick, s_valid, s_done, s_busy;
    logic [0:0]  s_idx, s_didx, s_way, s_dway;
    logic [15:0] s_cnt;
    logic [7:0]  s_drop;

    int n_vec = 0;
    int n_err = 0;

    line_refresh_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick_period(period), .tick_en(tick),
        .stale_event(stale), .refresh_budget(budget), .refresh_valid(valid), .refresh_ready(ready),
        .refresh_index(idx), .refresh_way(way), .refresh_done(done), .refresh_done_index(didx),
        .refresh_done_way(dway), .busy(busy), .refresh_count(cnt), .dropped_events(drop)
    );

    line_refresh_scheduler #(.NUM_SETS(2), .NUM_WAYS(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .enable(s_enable), .tick_period(s_period), .tick_en(s_tick),
        .stale_event(s_stale), .refresh_budget(s_budget), .refresh_valid(s_valid), .refresh_ready(s_ready),
        .refresh_index(s_idx), .refresh_way(s_way), .refresh_done(s_done), .refresh_done_index(s_didx),
        .refresh_done_way(s_dway), .busy(s_busy), .refresh_count(s_cnt), .dropped_events(s_drop)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        enable = 1'b0; stale = 1'b0; ready = 1'b0; period = '0; budget = '0;
        s_enable = 1'b0; s_stale = 1'b0; s_ready = 1'b0; s_budget = '0; s_period = '0;
        step;
        step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        n_vec++;
        if ({tick, valid, done, busy} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {tick, valid, done, busy});
        end
        n_vec++;
        if ({idx, way, didx, dway} !== 16'h0000) begin
            n_err++; $display("FAIL reset_lines: got %h want 0000", {idx, way, didx, dway});
        end
        n_vec++;
        if ({cnt, drop} !== 24'h000000) begin
            n_err++; $display("FAIL reset_counters: got cnt=%0d drop=%0d want 0/0", cnt, drop);
        end
        n_vec++;
        if ({s_valid, s_busy, s_idx, s_way, s_cnt} !== 20'h00000) begin
            n_err++; $display("FAIL reset_small: got valid=%b busy=%b ptr=(%0d,%0d) cnt=%0d want zeros",
                              s_valid, s_busy, s_idx, s_way, s_cnt);
        end
    endtask

    task automatic test_tick;
        logic exp;
        enable = 1'b1;
        period = 16'd4;
        for (int c = 1; c <= 13; c++) begin
            step;
            exp = ((c % 4) == 0);
            n_vec++;
            if (tick !== exp) begin
                n_err++; $display("FAIL tick_p4 cyc%0d: got %b want %b", c, tick, exp);
            end
        end
        period = 16'd0;
        for (int c = 0; c < 6; c++) begin
            step;
            n_vec++;
            if (tick !== 1'b0) begin
                n_err++; $display("FAIL tick_off cyc%0d: got %b want 0", c, tick);
            end
        end
        period = 16'd100;
        for (int c = 0; c < 50; c++) begin
            step;
            n_vec++;
            if (tick !== 1'b0) begin
                n_err++; $display("FAIL tick_p100 cyc%0d: got %b want 0", c, tick);
            end
        end
        period = 16'd2;
        step;
        n_vec++;
        if (tick !== 1'b1) begin
            n_err++; $display("FAIL tick_shrink: got %b want 1", tick);
        end
        step;
        n_vec++;
        if (tick !== 1'b0) begin
            n_err++; $display("FAIL tick_after_shrink: got %b want 0", tick);
        end
        period = 16'd0;
    endtask

    task automatic test_back_to_back;
        int         line;
        logic [5:0] es;
        logic [1:0] ew;
        do_reset;
        enable = 1'b1; budget = 8'd3; ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            stale = 1'b1;
            step;
            stale = 1'b0;
            n_vec++;
            if ({valid, busy} !== 2'b00) begin
                n_err++; $display("FAIL b2b_latency b%0d: got valid=%b busy=%b want 0/0", b, valid, busy);
            end
            step;
            for (int k = 0; k < 3; k++) begin
                line = b * 3 + k;
                es = 6'(line / 4);
                ew = 2'(line % 4);
                n_vec++;
                if ({valid, busy, idx, way} !== {2'b11, es, ew}) begin
                    n_err++; $display("FAIL b2b_req b%0d k%0d: got v=%b busy=%b (%0d,%0d) want 1/1 (%0d,%0d)",
                                      b, k, valid, busy, idx, way, es, ew);
                end
                step;
                n_vec++;
                if ({done, didx, dway} !== {1'b1, es, ew}) begin
                    n_err++; $display("FAIL b2b_done b%0d k%0d: got d=%b (%0d,%0d) want 1 (%0d,%0d)",
                                      b, k, done, didx, dway, es, ew);
                end
            end
            n_vec++;
            if ({valid, busy} !== 2'b00) begin
                n_err++; $display("FAIL b2b_end b%0d: got valid=%b busy=%b want 0/0", b, valid, busy);
            end
            n_vec++;
            if (cnt !== 16'(3 * (b + 1))) begin
                n_err++; $display("FAIL b2b_count b%0d: got %0d want %0d", b, cnt, 3 * (b + 1));
            end
            step;
            n_vec++;
            if (done !== 1'b0) begin
                n_err++; $display("FAIL b2b_done_clear b%0d: got %b want 0", b, done);
            end
        end
    endtask

    task automatic test_stall;
        do_reset;
        enable = 1'b1; budget = 8'd4; ready = 1'b0;
        stale = 1'b1;
        step;
        stale = 1'b0;
        step;
        for (int c = 0; c < 5; c++) begin
            step;
            n_vec++;
            if ({done, valid, idx, way} !== {2'b01, 6'd0, 2'd0}) begin
                n_err++; $display("FAIL stall_hold cyc%0d: got d=%b v=%b (%0d,%0d) want 0/1 (0,0)",
                                  c, done, valid, idx, way);
            end
        end
        ready = 1'b1;
        step;
        n_vec++;
        if ({done, didx, dway, valid, idx, way} !== {1'b1, 6'd0, 2'd0, 1'b1, 6'd0, 2'd1}) begin
            n_err++; $display("FAIL stall_accept: got d=%b (%0d,%0d) v=%b (%0d,%0d) want 1 (0,0) 1 (0,1)",
                              done, didx, dway, valid, idx, way);
        end
        ready = 1'b0;
        step;
        n_vec++;
        if ({done, valid, idx, way, cnt} !== {2'b01, 6'd0, 2'd1, 16'd1}) begin
            n_err++; $display("FAIL stall_single_done: got d=%b v=%b (%0d,%0d) cnt=%0d want 0/1 (0,1) 1",
                              done, valid, idx, way, cnt);
        end
        ready = 1'b1;
        step; step; step;
        n_vec++;
        if ({valid, busy, cnt} !== {2'b00, 16'd4}) begin
            n_err++; $display("FAIL stall_finish: got v=%b busy=%b cnt=%0d want 0/0 4", valid, busy, cnt);
        end
    endtask

    task automatic test_wrap;
        logic [0:0] es, ew;
        do_reset;
        s_enable = 1'b1; s_budget = 8'd0; s_ready = 1'b1;
        s_stale = 1'b1;
        step;
        s_stale = 1'b0;
        step;
        for (int k = 0; k < 4; k++) begin
            es = 1'(k / 2);
            ew = 1'(k % 2);
            n_vec++;
            if ({s_valid, s_idx, s_way} !== {1'b1, es, ew}) begin
                n_err++; $display("FAIL wrap_req k%0d: got v=%b (%0d,%0d) want 1 (%0d,%0d)",
                                  k, s_valid, s_idx, s_way, es, ew);
            end
            step;
            n_vec++;
            if ({s_done, s_didx, s_dway} !== {1'b1, es, ew}) begin
                n_err++; $display("FAIL wrap_done k%0d: got d=%b (%0d,%0d) want 1 (%0d,%0d)",
                                  k, s_done, s_didx, s_dway, es, ew);
            end
        end
        n_vec++;
        if ({s_valid, s_busy, s_cnt} !== {2'b00, 16'd4}) begin
            n_err++; $display("FAIL wrap_end: got v=%b busy=%b cnt=%0d want 0/0 4", s_valid, s_busy, s_cnt);
        end
        s_stale = 1'b1;
        step;
        s_stale = 1'b0;
        step;
        n_vec++;
        if ({s_valid, s_idx, s_way} !== 3'b100) begin
            n_err++; $display("FAIL wrap_pointer: got v=%b (%0d,%0d) want 1 (0,0)", s_valid, s_idx, s_way);
        end
        s_enable = 1'b0;
    endtask

    task automatic test_drop;
        do_reset;
        enable = 1'b1; budget = 8'd8; ready = 1'b1;
        stale = 1'b1;
        step;
        stale = 1'b0;
        step;
        n_vec++;
        if ({valid, idx, way} !== {1'b1, 6'd0, 2'd0}) begin
            n_err++; $display("FAIL drop_start: got v=%b (%0d,%0d) want 1 (0,0)", valid, idx, way);
        end
        stale = 1'b1;
        step; step; step;
        stale = 1'b0;
        n_vec++;
        if (drop !== 8'd2) begin
            n_err++; $display("FAIL drop_count: got %0d want 2", drop);
        end
        step; step; step; step;
        step;
        n_vec++;
        if ({valid, busy, done, didx, dway, cnt} !== {3'b001, 6'd1, 2'd3, 16'd8}) begin
            n_err++; $display("FAIL drop_burst_end: got v=%b busy=%b d=%b (%0d,%0d) cnt=%0d want 0/0/1 (1,3) 8",
                              valid, busy, done, didx, dway, cnt);
        end
        step;
        n_vec++;
        if ({valid, busy, idx, way, drop} !== {2'b11, 6'd2, 2'd0, 8'd2}) begin
            n_err++; $display("FAIL drop_next_burst: got v=%b busy=%b (%0d,%0d) drop=%0d want 1/1 (2,0) 2",
                              valid, busy, idx, way, drop);
        end
    endtask

    task automatic test_enable_drop;
        do_reset;
        enable = 1'b1; budget = 8'd8; ready = 1'b0;
        stale = 1'b1;
        step;
        stale = 1'b0;
        step;
        enable = 1'b0;
        step; step;
        n_vec++;
        if ({valid, busy, idx, way} !== {2'b11, 6'd0, 2'd0}) begin
            n_err++; $display("FAIL en_hold: got v=%b busy=%b (%0d,%0d) want 1/1 (0,0)", valid, busy, idx, way);
        end
        ready = 1'b1;
        step;
        n_vec++;
        if ({done, didx, dway, valid, busy, cnt} !== {1'b1, 6'd0, 2'd0, 2'b00, 16'd1}) begin
            n_err++; $display("FAIL en_complete: got d=%b (%0d,%0d) v=%b busy=%b cnt=%0d want 1 (0,0) 0/0 1",
                              done, didx, dway, valid, busy, cnt);
        end
        step;
        n_vec++;
        if ({valid, busy, done} !== 3'b000) begin
            n_err++; $display("FAIL en_idle: got v=%b busy=%b d=%b want 000", valid, busy, done);
        end
        stale = 1'b1;
        step;
        stale = 1'b0;
        step;
        n_vec++;
        if ({valid, busy} !== 2'b00) begin
            n_err++; $display("FAIL en_pending_wait: got v=%b busy=%b want 0/0", valid, busy);
        end
        enable = 1'b1;
        step;
        n_vec++;
        if ({valid, idx, way} !== {1'b1, 6'd0, 2'd1}) begin
            n_err++; $display("FAIL en_pending_kept: got v=%b (%0d,%0d) want 1 (0,1)", valid, idx, way);
        end
    endtask

    task automatic test_reset_mid;
        logic exp;
        do_reset;
        enable = 1'b1; budget = 8'd8; ready = 1'b1; period = 16'd4;
        stale = 1'b1;
        step;
        stale = 1'b0;
        step; step; step;
        rst_n = 1'b0;
        step;
        n_vec++;
        if ({valid, busy, done, tick, idx, way, didx, dway} !== 20'h00000) begin
            n_err++; $display("FAIL midrst_outputs: got v=%b busy=%b d=%b t=%b (%0d,%0d) done(%0d,%0d) want zeros",
                              valid, busy, done, tick, idx, way, didx, dway);
        end
        n_vec++;
        if ({cnt, drop} !== 24'h000000) begin
            n_err++; $display("FAIL midrst_counters: got cnt=%0d drop=%0d want 0/0", cnt, drop);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step;
            exp = (c == 4);
            n_vec++;
            if ({tick, done} !== {exp, 1'b0}) begin
                n_err++; $display("FAIL midrst_tick cyc%0d: got t=%b d=%b want %b/0", c, tick, done, exp);
            end
        end
        period = 16'd0;
        stale = 1'b1;
        step;
        stale = 1'b0;
        step;
        n_vec++;
        if ({valid, idx, way} !== {1'b1, 6'd0, 2'd0}) begin
            n_err++; $display("FAIL midrst_pointer: got v=%b (%0d,%0d) want 1 (0,0)", valid, idx, way);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_tick;
        test_back_to_back;
        test_stall;
        test_wrap;
        test_drop;
        test_enable_drop;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
